gshare_predictor: RTL and testbench
===================================

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 The block SHALL expose these parameters, one per line:
- WIDTH_INDEX, 10, log2 of pattern-table entries.
- WIDTH_HIST, 10, global history bits; WIDTH_HIST <= WIDTH_INDEX, else elaboration error.
- WIDTH_CTR, 2, saturating-counter width; valid range 1..4.
- MODE, 1, 0 = history-only index, 1 = gshare index.
- CTR_INIT, 2^(WIDTH_CTR-1)-1, post-reset counter value (weakly not-taken).
REQ-002 Ports, one per line:
- clk  in  1  sole clock; the block has one clock.
- rst_n  in  1  reset; asynchronous, active-low.
- pc  in  Addr  fetch address to predict.
- pred_req  in  1  fetch consumes a prediction this cycle.
- pred_taken  out  1  prediction for pc.
- pred_hist  out  WIDTH_HIST  speculative history used for this prediction; fetch carries it down the pipe.
- ready  out  1  table initialised; predictions are meaningful.
- brinfo  in  BrInfo  resolved branch (valid, pc, taken).
- br_hist  in  WIDTH_HIST  pred_hist captured at fetch for brinfo's branch.
- br_mispred  in  1  brinfo's branch was mispredicted; qualified by brinfo.valid.

Function
REQ-003 Lookup index SHALL be pc[WIDTH_INDEX+1:2] XOR zero-extended spec_hist when MODE=1, and zero-extended spec_hist when MODE=0.
REQ-004 Update index SHALL be formed identically from brinfo.pc and br_hist, never from current spec_hist.
REQ-005 pred_taken SHALL be combinational, equal to the MSB of the indexed counter when ready=1, and 0 when ready=0.
REQ-006 pred_hist SHALL equal spec_hist combinationally.
REQ-007 On a clock edge with ready=1, pred_req=1 and no mispredict, spec_hist SHALL shift left by one, inserting pred_taken at the LSB.
REQ-008 On a clock edge with brinfo.valid=1 and br_mispred=1, spec_hist SHALL load {br_hist[WIDTH_HIST-2:0], brinfo.taken}.
REQ-009 A mispredict repair SHALL take priority over a simultaneous pred_req shift.
REQ-010 On a clock edge with ready=1 and brinfo.valid=1, the counter at the update index SHALL increment if taken and decrement if not taken.
REQ-011 Counter updates SHALL saturate at 2^WIDTH_CTR-1 and at 0; the entry is unchanged at a saturated bound.
REQ-012 Updates SHALL be written at the clock edge; a lookup to the same index in the same cycle SHALL return the pre-update value, and the next cycle SHALL return the new value.
REQ-013 brinfo.valid and br_mispred received while ready=0 SHALL be dropped; spec_hist SHALL stay 0.

Reset
REQ-014 While rst_n=0: spec_hist=0, ready=0, init pointer=0, and pred_taken SHALL be 0.
REQ-015 After rst_n deasserts, an INIT state SHALL write CTR_INIT to one entry per cycle, indices 0 to 2^WIDTH_INDEX-1.
REQ-016 ready SHALL rise on the cycle after the last INIT write, 2^WIDTH_INDEX cycles after deassertion, and the FSM SHALL enter READY.
REQ-017 Reset asserted in any state, including mid-INIT, SHALL immediately return the FSM to INIT with the pointer at 0.
REQ-018 The FSM SHALL have exactly two states, INIT and READY, and SHALL never leave READY except by reset.

Structure
REQ-019 Addr and BrInfo SHALL come from the shared basic-types package; a GshareMode enum and CTR_INIT default SHALL be added to the same package.
REQ-020 The pattern table SHALL be a single-write-port, single-read-port array with no reset on its contents, so it maps to RAM.
REQ-021 Saturating next-value logic SHALL be one sub-module, sat_counter_next, parameterised by WIDTH_CTR.

Verification
REQ-022 The bench SHALL cover these scenarios, with WIDTH_INDEX=4, WIDTH_HIST=4, WIDTH_CTR=2, MODE=1 unless stated:
- Reset release -> ready=0 for 16 cycles, then 1; every entry reads 01; pred_taken=0.
- Three taken updates, pc=0x40, br_hist=0 -> entry 0 reads 10, then 11, then 11 (saturated); pred_taken=1 after the first update.
- pred_req with pred_taken=1 on four cycles -> pred_hist sequence 0000, 0001, 0011, 0111.
- Same cycle: pred_req=1 and mispredict with br_hist=1010, taken=0 -> spec_hist=0100; the shift is ignored.
- Update and lookup of the same index in one cycle -> old value returned; new value on the next cycle.
- rst_n pulsed at INIT pointer 7 -> pointer restarts at 0; ready rises 16 cycles after the second release.
- MODE=0, pc=0x44 versus pc=0x48 with equal history -> same entry is addressed.

Source files
------------

// File: rtl/gshare_predictor_pkg.sv
// Shared basic types for the branch-prediction slice, plus the gshare mode
// selector, FSM states and the default counter initialisation value.
package gshare_predictor_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] Addr;

  typedef struct packed {
    logic valid;
    Addr  pc;
    logic taken;
  } BrInfo;

  typedef enum logic {
    GSHARE_HIST_ONLY = 1'b0,
    GSHARE_XOR       = 1'b1
  } GshareMode;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } GshareState;

  // Weakly not-taken: one below the counter midpoint.
  function automatic int ctr_init_default(int width_ctr);
    return (1 << (width_ctr - 1)) - 1;
  endfunction

  localparam int CTR_INIT_DEFAULT = ctr_init_default(2);

endpackage

// File: rtl/gshare_predictor_sat_counter_next.sv
// Next-value logic for an up/down saturating counter: moves one step toward
// the branch outcome and holds at either bound.
module sat_counter_next #(
  parameter int WIDTH_CTR = 2
) (
  input  logic [WIDTH_CTR-1:0] ctr,
  input  logic                 taken,
  output logic [WIDTH_CTR-1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken && (ctr != '1)) begin
      ctr_next = ctr + WIDTH_CTR'(1);
    end else if (!taken && (ctr != '0)) begin
      ctr_next = ctr - WIDTH_CTR'(1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch predictor: saturating counters indexed by fetch PC hashed with
// speculative global history, trained and repaired from resolved branches.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int WIDTH_INDEX = 10,
  parameter int WIDTH_HIST  = 10,
  parameter int WIDTH_CTR   = 2,
  parameter int MODE        = 1,
  parameter int CTR_INIT    = ctr_init_default(WIDTH_CTR)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  Addr                   pc,
  input  logic                  pred_req,
  output logic                  pred_taken,
  output logic [WIDTH_HIST-1:0] pred_hist,
  output logic                  ready,
  input  BrInfo                 brinfo,
  input  logic [WIDTH_HIST-1:0] br_hist,
  input  logic                  br_mispred
);

  localparam int ENTRIES = 2 ** WIDTH_INDEX;

  if (WIDTH_HIST > WIDTH_INDEX) begin : g_bad_hist
    $error("gshare_predictor: WIDTH_HIST must not exceed WIDTH_INDEX");
  end
  if ((WIDTH_CTR < 1) || (WIDTH_CTR > 4)) begin : g_bad_ctr
    $error("gshare_predictor: WIDTH_CTR must be in 1..4");
  end

  GshareState             state;
  logic [WIDTH_INDEX-1:0] init_ptr;
  logic [WIDTH_HIST-1:0]  spec_hist;
  logic [WIDTH_CTR-1:0]   pht [ENTRIES];
  logic [WIDTH_INDEX-1:0] lookup_idx, update_idx, pht_waddr;
  logic [WIDTH_CTR-1:0]   lookup_ctr, update_ctr, update_next, pht_wdata;
  logic                   pht_we;
  logic [WIDTH_HIST:0]    shift_ext, repair_ext;
  logic                   unused_bits;

  function automatic logic [WIDTH_INDEX-1:0] make_index(Addr addr, logic [WIDTH_HIST-1:0] hist);
    logic [WIDTH_INDEX-1:0] hist_ext;
    hist_ext = WIDTH_INDEX'(hist);
    if (MODE == int'(GSHARE_XOR)) begin
      return addr[WIDTH_INDEX+1:2] ^ hist_ext;
    end
    return hist_ext;
  endfunction

  assign lookup_idx = make_index(pc, spec_hist);
  assign update_idx = make_index(brinfo.pc, br_hist);

  // Fetch lookup and the resolving branch's read-modify-write each get a read.
  assign lookup_ctr = pht[lookup_idx];
  assign update_ctr = pht[update_idx];

  sat_counter_next #(
    .WIDTH_CTR(WIDTH_CTR)
  ) u_sat_counter_next (
    .ctr      (update_ctr),
    .taken    (brinfo.taken),
    .ctr_next (update_next)
  );

  assign pred_taken  = ready & lookup_ctr[WIDTH_CTR-1];
  assign pred_hist   = spec_hist;
  assign shift_ext   = {spec_hist, pred_taken};
  assign repair_ext  = {br_hist, brinfo.taken};
  assign unused_bits = ^{pc, brinfo.pc, shift_ext[WIDTH_HIST], repair_ext[WIDTH_HIST], lookup_ctr};

  // INIT sweeps one entry per cycle; READY is left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_ptr <= '0;
      ready    <= 1'b0;
    end else if (state == ST_INIT) begin
      if (&init_ptr) begin
        state <= ST_READY;
        ready <= 1'b1;
      end else begin
        init_ptr <= init_ptr + WIDTH_INDEX'(1);
      end
    end
  end

  // A mispredict repair wins over the speculative shift of the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_hist <= '0;
    end else if (ready) begin
      if (brinfo.valid && br_mispred) begin
        spec_hist <= repair_ext[WIDTH_HIST-1:0];
      end else if (pred_req) begin
        spec_hist <= shift_ext[WIDTH_HIST-1:0];
      end
    end
  end

  always_comb begin
    pht_we    = 1'b0;
    pht_waddr = init_ptr;
    pht_wdata = WIDTH_CTR'(CTR_INIT);
    if (state == ST_INIT) begin
      pht_we = 1'b1;
    end else if (brinfo.valid) begin
      pht_we    = 1'b1;
      pht_waddr = update_idx;
      pht_wdata = update_next;
    end
  end

  // Contents are deliberately not reset so the table maps onto RAM.
  always_ff @(posedge clk) begin
    if (pht_we) begin
      pht[pht_waddr] <= pht_wdata;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed vector table plus random
// traffic against a behavioural model, on a gshare and a history-only instance.
module tb_gshare_predictor;
  import gshare_predictor_pkg::*;

  localparam int WI      = 4;
  localparam int WH      = 4;
  localparam int ENTRIES = 16;

  logic       clk;
  logic       rst_n;
  Addr        pc;
  logic       pred_req;
  BrInfo      brinfo;
  logic [3:0] br_hist;
  logic       br_mispred;
  logic       pred_taken, pred_taken0;
  logic [3:0] pred_hist, pred_hist0;
  logic       ready, ready0;

  int n_cmp;
  int n_fail;

  // Model state: index 1 is the gshare instance, index 0 the history-only one.
  int mpht [2][ENTRIES];
  int mhist [2];
  bit mready;
  int init_cnt;

  typedef struct {
    Addr        pc;
    bit         req;
    bit         bv;
    Addr        bpc;
    bit         bt;
    bit         bm;
    logic [3:0] bh;
    bit         exp_t;
    bit         exp_t0;
    logic [3:0] exp_h;
  } vec_t;

  vec_t vecs [21];

  gshare_predictor #(
    .WIDTH_INDEX(WI), .WIDTH_HIST(WH), .WIDTH_CTR(2), .MODE(1), .CTR_INIT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pred_req(pred_req),
    .pred_taken(pred_taken), .pred_hist(pred_hist), .ready(ready),
    .brinfo(brinfo), .br_hist(br_hist), .br_mispred(br_mispred)
  );

  gshare_predictor #(
    .WIDTH_INDEX(WI), .WIDTH_HIST(WH), .WIDTH_CTR(2), .MODE(0), .CTR_INIT(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pred_req(pred_req),
    .pred_taken(pred_taken0), .pred_hist(pred_hist0), .ready(ready0),
    .brinfo(brinfo), .br_hist(br_hist), .br_mispred(br_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int midx(int m, Addr a, int h);
    if (m == 1) return int'((a >> 2) & 32'hF) ^ h;
    return h;
  endfunction

  function automatic bit mpred(int m);
    return mready && (mpht[m][midx(m, pc, mhist[m])] >= 2);
  endfunction

  task automatic model_reset();
    mready   = 1'b0;
    init_cnt = 0;
    mhist[0] = 0;
    mhist[1] = 0;
  endtask

  // Applies the clock-edge rules of the predictor to the model.
  task automatic model_clock();
    bit p [2];
    int i;
    p[0] = mpred(0);
    p[1] = mpred(1);
    if (!mready) begin
      init_cnt++;
      if (init_cnt == ENTRIES) begin
        mready = 1'b1;
        for (int m = 0; m < 2; m++)
          for (int e = 0; e < ENTRIES; e++) mpht[m][e] = 1;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (brinfo.valid) begin
          i = midx(m, brinfo.pc, int'(br_hist));
          if (brinfo.taken && mpht[m][i] < 3) mpht[m][i]++;
          else if (!brinfo.taken && mpht[m][i] > 0) mpht[m][i]--;
        end
        if (brinfo.valid && br_mispred)
          mhist[m] = ((int'(br_hist) << 1) | int'(brinfo.taken)) & 15;
        else if (pred_req)
          mhist[m] = ((mhist[m] << 1) | int'(p[m])) & 15;
      end
    end
  endtask

  task automatic apply_stimulus(input Addr a, input bit req, input bit bv, input Addr bpc,
                                input bit bt, input bit bm, input logic [3:0] bh);
    pc           = a;
    pred_req     = req;
    brinfo.valid = bv;
    brinfo.pc    = bpc;
    brinfo.taken = bt;
    br_mispred   = bm;
    br_hist      = bh;
    #4;
  endtask

  task automatic check_model();
    check_output("ready", 32'(ready), 32'(mready));
    check_output("ready_m0", 32'(ready0), 32'(mready));
    check_output("pred_taken", 32'(pred_taken), 32'(mpred(1)));
    check_output("pred_taken_m0", 32'(pred_taken0), 32'(mpred(0)));
    check_output("pred_hist", 32'(pred_hist), 32'(mhist[1]));
    check_output("pred_hist_m0", 32'(pred_hist0), 32'(mhist[0]));
  endtask

  task automatic advance();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  function automatic vec_t mk(Addr a, bit req, bit bv, Addr bpc, bit bt, bit bm,
                              logic [3:0] bh, bit et, bit et0, logic [3:0] eh);
    vec_t v;
    v.pc = a; v.req = req; v.bv = bv; v.bpc = bpc; v.bt = bt; v.bm = bm; v.bh = bh;
    v.exp_t = et; v.exp_t0 = et0; v.exp_h = eh;
    return v;
  endfunction

  initial begin
    int cycles;
    n_cmp  = 0;
    n_fail = 0;

    // Counter training, saturation, history shift, repair priority,
    // same-index read-before-write, then history-only aliasing of 0x44/0x48.
    vecs[0]  = mk(32'h40, 0, 1, 32'h40, 1, 0, 4'h0, 0, 0, 4'h0);
    vecs[1]  = mk(32'h40, 0, 1, 32'h40, 1, 0, 4'h0, 1, 1, 4'h0);
    vecs[2]  = mk(32'h40, 0, 1, 32'h40, 1, 0, 4'h0, 1, 1, 4'h0);
    vecs[3]  = mk(32'h40, 0, 0, 32'h00, 0, 0, 4'h0, 1, 1, 4'h0);
    vecs[4]  = mk(32'h40, 0, 1, 32'h40, 1, 0, 4'h1, 1, 1, 4'h0);
    vecs[5]  = mk(32'h40, 0, 1, 32'h40, 1, 0, 4'h3, 1, 1, 4'h0);
    vecs[6]  = mk(32'h40, 0, 1, 32'h40, 1, 0, 4'h7, 1, 1, 4'h0);
    vecs[7]  = mk(32'h40, 1, 0, 32'h00, 0, 0, 4'h0, 1, 1, 4'h0);
    vecs[8]  = mk(32'h40, 1, 0, 32'h00, 0, 0, 4'h0, 1, 1, 4'h1);
    vecs[9]  = mk(32'h40, 1, 0, 32'h00, 0, 0, 4'h0, 1, 1, 4'h3);
    vecs[10] = mk(32'h40, 1, 0, 32'h00, 0, 0, 4'h0, 1, 1, 4'h7);
    vecs[11] = mk(32'h40, 1, 1, 32'h40, 0, 1, 4'hA, 0, 0, 4'hF);
    vecs[12] = mk(32'h40, 0, 0, 32'h00, 0, 0, 4'h0, 0, 0, 4'h4);
    vecs[13] = mk(32'h40, 0, 1, 32'h40, 1, 0, 4'h4, 0, 0, 4'h4);
    vecs[14] = mk(32'h40, 0, 0, 32'h00, 0, 0, 4'h0, 1, 1, 4'h4);
    vecs[15] = mk(32'h40, 0, 1, 32'h40, 0, 1, 4'h0, 1, 1, 4'h4);
    vecs[16] = mk(32'h44, 0, 0, 32'h00, 0, 0, 4'h0, 1, 1, 4'h0);
    vecs[17] = mk(32'h48, 0, 0, 32'h00, 0, 0, 4'h0, 0, 1, 4'h0);
    vecs[18] = mk(32'h48, 0, 1, 32'h44, 0, 0, 4'h0, 0, 1, 4'h0);
    vecs[19] = mk(32'h44, 0, 0, 32'h00, 0, 0, 4'h0, 0, 0, 4'h0);
    vecs[20] = mk(32'h48, 0, 0, 32'h00, 0, 0, 4'h0, 0, 0, 4'h0);

    // Reset held with branch traffic present: everything must stay quiet.
    rst_n = 1'b0;
    model_reset();
    apply_stimulus(32'h40, 1, 1, 32'h40, 1, 1, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_ready", 32'(ready), 32'h0);
    check_output("rst_ready_m0", 32'(ready0), 32'h0);
    check_output("rst_pred_taken", 32'(pred_taken), 32'h0);
    check_output("rst_pred_taken_m0", 32'(pred_taken0), 32'h0);
    check_output("rst_pred_hist", 32'(pred_hist), 32'h0);
    check_output("rst_pred_hist_m0", 32'(pred_hist0), 32'h0);

    // Release, run to INIT pointer 7, then pulse reset mid-INIT.
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      apply_stimulus(Addr'($urandom), 1, 1, Addr'($urandom), 1, 1, 4'hF);
      check_model();
      advance();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("midinit_rst_ready", 32'(ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Branch traffic during INIT is dropped; ready needs a full 16-cycle sweep.
    cycles = 0;
    while (!ready && cycles < 40) begin
      apply_stimulus(Addr'($urandom), 1, 1, Addr'($urandom), 1, 1, 4'hF);
      check_model();
      advance();
      cycles++;
    end
    check_output("ready_latency", 32'(cycles), 32'd16);

    // Every entry starts weakly not-taken.
    for (int e = 0; e < ENTRIES; e++) begin
      apply_stimulus(Addr'(e << 2), 0, 0, '0, 0, 0, 4'h0);
      check_output("init_entry_pred", 32'(pred_taken), 32'h0);
      check_model();
      advance();
    end

    foreach (vecs[v]) begin
      apply_stimulus(vecs[v].pc, vecs[v].req, vecs[v].bv, vecs[v].bpc,
                     vecs[v].bt, vecs[v].bm, vecs[v].bh);
      check_output($sformatf("vec%0d_pred_taken", v), 32'(pred_taken), 32'(vecs[v].exp_t));
      check_output($sformatf("vec%0d_pred_taken_m0", v), 32'(pred_taken0), 32'(vecs[v].exp_t0));
      check_output($sformatf("vec%0d_pred_hist", v), 32'(pred_hist), 32'(vecs[v].exp_h));
      check_model();
      advance();
    end

    for (int r = 0; r < 400; r++) begin
      apply_stimulus(Addr'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     Addr'($urandom), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
      check_model();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
